// File: rtl/mm_pkg.sv
// Shared constants and types for the memory map unit: register offsets,
// page index width and the wait-state FSM encoding.
package mm_pkg;

  localparam logic [3:0] REG_IO_BANK = 4'h0;
  localparam logic [3:0] REG_ROM_SEL = 4'h1;
  localparam logic [3:0] REG_WP_MASK = 4'h2;
  localparam logic [3:0] REG_STATUS  = 4'h3;
  localparam logic [3:0] REG_IO_WAIT = 4'h4;
  localparam logic [3:0] REG_PAGE0   = 4'h8;

  localparam int PAGE_W = 3;

  typedef enum logic {
    WS_IDLE = 1'b0,
    WS_WAIT = 1'b1
  } wait_state_t;

endpackage

// File: rtl/mem_map_unit_if.sv
// CPU-side bus of the memory map unit. The CPU presents an access with req_i
// and holds address/data until rdy_o is 1; the access completes on that edge.
interface mem_map_unit_if #(
  parameter int N_IO   = 8,
  parameter int PHYS_W = 19
);
  import mm_pkg::*;

  logic              req_i;
  logic              R_W_n;
  logic [15:0]       addr_i;
  logic [7:0]        data_i;
  logic [7:0]        data_o;
  logic              rdy_o;
  logic              ram_cs;
  logic              ram_we;
  logic [PHYS_W-1:0] ram_addr_o;
  logic              rom_cs;
  logic [N_IO-1:0]   io_cs;
  logic              reg_cs;
  logic              wp_fault_o;
  wait_state_t       wait_state;

  modport master (
    output req_i, R_W_n, addr_i, data_i,
    input  data_o, rdy_o, ram_cs, ram_we, ram_addr_o, rom_cs, io_cs, reg_cs,
           wp_fault_o, wait_state
  );

  modport slave (
    input  req_i, R_W_n, addr_i, data_i,
    output data_o, rdy_o, ram_cs, ram_we, ram_addr_o, rom_cs, io_cs, reg_cs,
           wp_fault_o, wait_state
  );
endinterface

// File: rtl/mm_wait_gen.sv
// IO wait-state generator: holds rdy low for exactly len_i cycles per started
// access. The counter is loaded with len_i-1 so the final WAIT cycle releases.
module mm_wait_gen
  import mm_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [3:0]  len_i,
  input  logic        abort_i,
  output logic        rdy_o,
  output wait_state_t state_o
);

  wait_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        kick;

  assign kick    = start_i && (len_i != 4'd0);
  assign state_o = state_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= WS_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      WS_IDLE: begin
        if (kick) begin
          state_d = WS_WAIT;
          cnt_d   = len_i - 4'd1;
        end
      end
      WS_WAIT: begin
        if (abort_i || cnt_q == 4'd0) state_d = WS_IDLE;
        else                          cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = WS_IDLE;
    endcase
  end

  // cnt_q == 0 in WAIT is the completing cycle, so the held access cannot retrigger.
  always_comb begin
    rdy_o = 1'b1;
    case (state_q)
      WS_IDLE: rdy_o = ~kick;
      WS_WAIT: rdy_o = (cnt_q == 4'd0);
      default: rdy_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_map_unit.sv
// 6502 address decoder with page table, per-page write protection and
// programmable IO wait states.
module mem_map_unit
  import mm_pkg::*;
#(
  parameter int          N_IO     = 8,
  parameter int          PHYS_W   = 19,
  parameter logic [7:0]  IO_PAGE  = 8'hFE,
  parameter logic [15:0] ROM_BASE = 16'hE000
) (
  input logic clk_i,
  input logic rst_i,
  mem_map_unit_if.slave bus
);

  localparam int PPN_W = PHYS_W - 13;

  logic [7:0]       io_bank_q, rom_sel_q, wp_mask_q;
  logic [3:0]       io_wait_q;
  logic             status_q, status_d;
  logic             wp_fault_q;
  logic [PPN_W-1:0] page_q [8];

  logic             reg_cs, ram_cs, rom_cs, rdy;
  logic [N_IO-1:0]  io_cs;
  logic [PAGE_W-1:0] cpu_page;
  logic             prot, reg_wr, fault_set;
  logic [7:0]       rd_data;

  assign cpu_page = bus.addr_i[15:13];
  assign prot     = wp_mask_q[cpu_page];

  always_comb begin
    reg_cs = 1'b0;
    ram_cs = 1'b0;
    rom_cs = 1'b0;
    io_cs  = '0;
    if (bus.req_i) begin
      if (bus.addr_i[15:4] == 12'h000) begin
        reg_cs = 1'b1;
      end else if (bus.addr_i[15:8] == IO_PAGE) begin
        if (io_bank_q == 8'd0) rom_cs = 1'b1;
        else if (io_bank_q > 8'(N_IO)) ram_cs = 1'b1;
        else begin
          for (int i = 0; i < N_IO; i++)
            if (io_bank_q == 8'(i + 1)) io_cs[i] = 1'b1;
        end
      end else if (bus.addr_i >= ROM_BASE && rom_sel_q == 8'd0) begin
        rom_cs = 1'b1;
      end else begin
        ram_cs = 1'b1;
      end
    end
  end

  mm_wait_gen u_wait (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (bus.req_i && (io_cs != '0)),
    .len_i   (io_wait_q),
    .abort_i (~bus.req_i),
    .rdy_o   (rdy),
    .state_o (bus.wait_state)
  );

  assign reg_wr    = bus.req_i & reg_cs & ~bus.R_W_n & rdy;
  assign fault_set = bus.req_i & ram_cs & ~bus.R_W_n & prot & rdy;

  // A fault set in the same cycle as a status write must win.
  always_comb begin
    status_d = status_q;
    if (fault_set) status_d = 1'b1;
    else if (reg_wr && bus.addr_i[3:0] == REG_STATUS) status_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      io_bank_q  <= 8'd0;
      rom_sel_q  <= 8'd0;
      wp_mask_q  <= 8'd0;
      io_wait_q  <= 4'd0;
      status_q   <= 1'b0;
      wp_fault_q <= 1'b0;
      for (int p = 0; p < 8; p++) page_q[p] <= PPN_W'(p);
    end else begin
      status_q   <= status_d;
      wp_fault_q <= fault_set;
      if (reg_wr) begin
        if (bus.addr_i[3]) page_q[bus.addr_i[2:0]] <= PPN_W'(bus.data_i);
        else begin
          case (bus.addr_i[3:0])
            REG_IO_BANK: io_bank_q <= bus.data_i;
            REG_ROM_SEL: rom_sel_q <= bus.data_i;
            REG_WP_MASK: wp_mask_q <= bus.data_i;
            REG_IO_WAIT: io_wait_q <= bus.data_i[3:0];
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    rd_data = 8'd0;
    if (bus.addr_i[3]) rd_data = 8'(page_q[bus.addr_i[2:0]]);
    else begin
      case (bus.addr_i[3:0])
        REG_IO_BANK: rd_data = io_bank_q;
        REG_ROM_SEL: rd_data = rom_sel_q;
        REG_WP_MASK: rd_data = wp_mask_q;
        REG_STATUS:  rd_data = {7'd0, status_q};
        REG_IO_WAIT: rd_data = {4'd0, io_wait_q};
        default:     rd_data = 8'd0;
      endcase
    end
  end

  assign bus.data_o     = (reg_cs && bus.R_W_n) ? rd_data : 8'd0;
  assign bus.rdy_o      = rdy;
  assign bus.reg_cs     = reg_cs;
  assign bus.ram_cs     = ram_cs;
  assign bus.rom_cs     = rom_cs;
  assign bus.io_cs      = io_cs;
  assign bus.ram_we     = ram_cs & ~bus.R_W_n & ~prot;
  assign bus.ram_addr_o = {page_q[cpu_page], bus.addr_i[12:0]};
  assign bus.wp_fault_o = wp_fault_q;

endmodule

// File: tb/tb_mem_map_unit.sv
// Scoreboard bench for mem_map_unit: directed accesses push an expected output
// record; a negedge monitor compares it when the access completes (rdy_o = 1).
module tb_mem_map_unit;
  localparam int W = 39;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_map_unit_if bus ();
  mem_map_unit dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  logic [W-1:0] exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;
  logic acc_active = 1'b0;

  function automatic logic [W-1:0] rec(bit ram, bit we, bit rom, bit rg,
                                       logic [7:0] io, logic [18:0] a, logic [7:0] d);
    return {ram, we, rom, rg, io, a, d};
  endfunction

  // Monitor: the address field only matters when RAM is selected.
  always @(negedge clk) begin
    if (acc_active && bus.req_i && bus.rdy_o) begin
      logic [W-1:0] act, exp;
      act = {bus.ram_cs, bus.ram_we, bus.rom_cs, bus.reg_cs, bus.io_cs,
             bus.ram_cs ? bus.ram_addr_o : 19'h0, bus.data_o};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL access addr=%h: unexpected completion got %h", bus.addr_i, act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          n_err++;
          $display("FAIL access addr=%h: got %h want %h", bus.addr_i, act, exp);
        end
      end
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Called just after a posedge; returns just after the completing edge.
  task automatic access(bit rd, logic [15:0] a, logic [7:0] d, logic [W-1:0] exp, int exp_stall);
    int stalls = 0;
    bit done = 0;
    exp_q.push_back(exp);
    bus.req_i = 1'b1; bus.R_W_n = rd; bus.addr_i = a; bus.data_i = d;
    acc_active = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (bus.rdy_o) done = 1;
      else stalls++;
      @(posedge clk); #1;
    end
    acc_active = 1'b0;
    bus.req_i = 1'b0; bus.R_W_n = 1'b1;
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL timeout addr=%h: rdy_o never rose", a);
      void'(exp_q.pop_back());
    end
    check($sformatf("stall addr=%h", a), stalls, exp_stall);
  endtask

  task automatic rd(logic [15:0] a, logic [W-1:0] exp, int st = 0);
    access(1'b1, a, 8'h00, exp, st);
  endtask

  task automatic wr(logic [15:0] a, logic [7:0] d, logic [W-1:0] exp, int st = 0);
    access(1'b0, a, d, exp, st);
  endtask

  task automatic wr_reg(logic [3:0] off, logic [7:0] d);
    wr({12'h000, off}, d, rec(0, 0, 0, 1, 8'h00, 19'h0, 8'h00));
  endtask

  task automatic rd_reg(logic [3:0] off, logic [7:0] d);
    rd({12'h000, off}, rec(0, 0, 0, 1, 8'h00, 19'h0, d));
  endtask

  task automatic check_fault(bit exp);
    @(negedge clk);
    check("wp_fault_o", 32'(bus.wp_fault_o), 32'(exp));
    @(posedge clk); #1;
  endtask

  initial begin
    bus.req_i = 1'b0; bus.R_W_n = 1'b1; bus.addr_i = 16'h0000; bus.data_i = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset rdy_o", 32'(bus.rdy_o), 32'd1);
    check("reset wp_fault_o", 32'(bus.wp_fault_o), 32'd0);
    check("reset data_o", 32'(bus.data_o), 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) rd_reg(4'(8 + i), 8'(i));
    rd(16'h2345, rec(1, 0, 0, 0, 8'h00, 19'h02345, 8'h00));
    rd(16'h0010, rec(1, 0, 0, 0, 8'h00, 19'h00010, 8'h00));
    rd_reg(4'h5, 8'h00);

    wr_reg(4'h9, 8'h3F);
    rd(16'h3000, rec(1, 0, 0, 0, 8'h00, 19'h7F000, 8'h00));

    wr_reg(4'h2, 8'h04);
    wr(16'h4000, 8'h55, rec(1, 0, 0, 0, 8'h00, 19'h04000, 8'h00));
    check_fault(1'b1);
    check_fault(1'b0);
    rd_reg(4'h3, 8'h01);
    wr_reg(4'h3, 8'h00);
    rd_reg(4'h3, 8'h00);
    wr(16'h6000, 8'hAA, rec(1, 1, 0, 0, 8'h00, 19'h06000, 8'h00));
    check_fault(1'b0);

    wr_reg(4'h0, 8'h03);
    wr_reg(4'h4, 8'h02);
    rd(16'hFE10, rec(0, 0, 0, 0, 8'b0000_0100, 19'h0, 8'h00), 2);
    rd(16'h2000, rec(1, 0, 0, 0, 8'h00, 19'h7E000, 8'h00));

    rd(16'hFFFF, rec(0, 0, 1, 0, 8'h00, 19'h0, 8'h00));
    wr_reg(4'h1, 8'h01);
    rd(16'hFFFF, rec(1, 0, 0, 0, 8'h00, 19'h0FFFF, 8'h00));
    wr_reg(4'h0, 8'h00);
    rd(16'hFE00, rec(0, 0, 1, 0, 8'h00, 19'h0, 8'h00));
    wr_reg(4'h0, 8'h09);
    rd(16'hFE00, rec(1, 0, 0, 0, 8'h00, 19'h0FE00, 8'h00));

    // Reset in the middle of a 5-cycle IO stall.
    wr_reg(4'h0, 8'h03);
    wr_reg(4'h4, 8'h05);
    bus.req_i = 1'b1; bus.R_W_n = 1'b1; bus.addr_i = 16'hFE10;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("stall before reset", 32'(bus.rdy_o), 32'd0);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rdy_o after reset", 32'(bus.rdy_o), 32'd1);
    check("rom_cs after reset", 32'(bus.rom_cs), 32'd1);
    @(posedge clk); #1;
    bus.req_i = 1'b0;
    rd_reg(4'h0, 8'h00);
    rd_reg(4'h1, 8'h00);
    rd_reg(4'h2, 8'h00);
    rd_reg(4'h4, 8'h00);
    rd_reg(4'h9, 8'h01);

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL scoreboard: %0d expected records left", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_map_unit.md
# mem_map_unit

Parametrised successor to the nano6502 address decoder. Turns the 6502 16-bit address into chip selects for RAM, ROM and N banked IO devices, and adds features the current decoder lacks:
- an 8-entry page table mapping each 8 KB CPU page onto a wider physical RAM address;
- per-page write protection with a sticky fault flag;
- a programmable IO wait-state generator that stalls the CPU through RDY.

It sits between the CPU core and the RAM/ROM/peripheral blocks in the top level.

## Interface
Parameters:
- N_IO, 8: number of IO devices; io_bank values 1..N_IO select device 0..N_IO-1, value 0 selects ROM.
- PHYS_W, 19: physical RAM address width (PHYS_W ≥ 16); physical page number width is PHYS_W-13.
- IO_PAGE, 8'hFE: CPU page (addr[15:8]) that forms the 256-byte IO window.
- ROM_BASE, 16'hE000: start of the ROM shadow, which runs to $FFFF.

Ports:
- clk_i, in, 1: clock. One clock; reset is synchronous and active-high.
- rst_i, in, 1: synchronous active-high reset.
- req_i, in, 1: CPU access valid this cycle.
- R_W_n, in, 1: 1 = read, 0 = write.
- addr_i, in, 16: CPU address.
- data_i, in, 8: CPU write data.
- data_o, out, 8: register read data, 0 when reg_cs = 0.
- rdy_o, out, 1: CPU ready; 0 stalls the CPU.
- ram_cs, out, 1: RAM select.
- ram_we, out, 1: RAM write enable.
- ram_addr_o, out, PHYS_W: physical RAM address.
- rom_cs, out, 1: ROM select.
- io_cs, out, N_IO: one-hot IO device select.
- reg_cs, out, 1: internal register access.
- wp_fault_o, out, 1: one-cycle pulse on a blocked write.

## Operation
Register map, $0000-$000F, reg_cs = 1, all read/write:
- $0000 io_bank.
- $0001 rom_sel: nonzero disables the ROM shadow.
- $0002 wp_mask: bit p protects CPU page p.
- $0003 status: bit0 = sticky fault, writing any value clears it; bits 7:1 read 0.
- $0004 io_wait[3:0]: wait states per IO access.
- $0008-$000F page[0..7]: physical page number; bits beyond PHYS_W-13 read 0.
- $0005-$0007 read 0, writes ignored.

Decode priority, all outputs combinational from addr_i, req_i and registers; every select is 0 when req_i = 0:
1. $0000-$000F: register access.
2. addr_i[15:8] = IO_PAGE: io_bank 0 → rom_cs; io_bank 1..N_IO → io_cs[io_bank-1]; otherwise → RAM.
3. addr_i ≥ ROM_BASE and rom_sel = 0: rom_cs, including $FFFF.
4. Everything else: RAM.

RAM address and write control:
- ram_addr_o = {page[addr_i[15:13]], addr_i[12:0]}.
- ram_we = ram_cs & ~R_W_n & ~wp_mask[addr_i[15:13]].
- A write to a protected page raises wp_fault_o and sets the sticky status bit.

Wait-state FSM (IDLE, WAIT):
- IDLE: when req_i and io_cs ≠ 0 and io_wait ≠ 0, load cnt = io_wait, drive rdy_o = 0, go to WAIT.
- WAIT: rdy_o = 0; cnt decrements each cycle; at cnt = 1, go to IDLE, where rdy_o = 1.
- Net effect: exactly io_wait stall cycles.
- The CPU holds address and data while rdy_o = 0.
- If req_i drops in WAIT, return to IDLE next cycle.
- RAM, ROM and register accesses never stall.

Register writes commit on the clock edge when req_i & reg_cs & ~R_W_n & rdy_o.

Fault handling:
- The fault sets on the cycle req_i & ram_cs & ~R_W_n & protected & rdy_o.
- A set takes priority over a same-cycle clear of the status register.

## Timing
- Reset values: io_bank 0, rom_sel 0, wp_mask 0, io_wait 0, page[p] = p (identity map), status 0, FSM IDLE.
- Output levels in reset: rdy_o = 1, wp_fault_o = 0, data_o = 0 unless a register is addressed.
- Decode latency is 0 cycles (combinational); register side effects are visible the cycle after the write edge.
- wp_fault_o is registered: it pulses for one cycle, the cycle after the blocked write.
- Asserting rst_i during WAIT forces IDLE and rdy_o = 1 on the next edge.
- A write to io_wait during an IO stall affects only the next IO access.

## Structure
- Shared package mm_pkg holds the register offset constants (REG_IO_BANK … REG_PAGE0), PAGE_W = 3, and the FSM state typedef.
- Sub-module mm_wait_gen holds the FSM and counter: inputs start, len, abort; output rdy.
- Decode and register file stay in mem_map_unit.

## Test plan
- Reset, then read $0008-$000F → 0..7. Access $2345 → ram_addr_o = 19'h02345, ram_cs = 1.
- Write page[1] = $3F, then read $3000 → ram_addr_o = 19'h7F000.
- Write wp_mask = $04, then write $4000:
  - ram_we = 0, wp_fault_o pulses one cycle later, $0003 reads $01;
  - writing $0003 clears it to $00.
- io_bank = 3, io_wait = 2, access $FE10 → io_cs = 8'b0000_0100, rdy_o low exactly 2 cycles.
- rom_sel = 0: $FFFF → rom_cs. rom_sel = 1: $FFFF → ram_cs. io_bank = 0: $FE00 → rom_cs.
- Assert rst_i mid-WAIT (io_wait = 5) → rdy_o = 1 the next cycle and all registers at reset values.
